// File: rtl/outdec_arbiter_4.sv
// Round-robin arbiter sharing one decimal-output engine among four requesters.
// Latches the winner's operands, pulses the engine start, waits for ready, returns done.
module outdec_arbiter_4 #(
    parameter int WD_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] n_bus,
    input  logic [31:0] delim1_bus,
    input  logic [31:0] delim2_bus,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        wd_err,
    output logic        eng_start,
    output logic [15:0] eng_n,
    output logic [7:0]  eng_delim1,
    output logic [7:0]  eng_delim2,
    input  logic        eng_result_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
    localparam logic [WD_W-1:0] WD_LAST = WD_MAX - WD_ONE;

    logic [1:0]      state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      done_q, done_d;
    logic            busy_q, busy_d;
    logic            wd_err_q, wd_err_d;
    logic            eng_start_q, eng_start_d;
    logic [15:0]     eng_n_q, eng_n_d;
    logic [7:0]      eng_delim1_q, eng_delim1_d;
    logic [7:0]      eng_delim2_q, eng_delim2_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic [1:0]      winner;
    logic [1:0]      scan_idx;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        winner   = ptr_q;
        scan_idx = '0;
        for (int k = 4; k >= 1; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        done_d       = 4'b0000;
        wd_err_d     = wd_err_q;
        eng_start_d  = 1'b0;
        eng_n_d      = eng_n_q;
        eng_delim1_d = eng_delim1_q;
        eng_delim2_d = eng_delim2_q;
        wd_cnt_d     = wd_cnt_q;

        case (state_q)
            S_IDLE: begin
                // The engine has no reset; only start it when it reports ready.
                if ((req != 4'b0000) && eng_result_ready) begin
                    ptr_d        = winner;
                    grant_d      = 4'b0001 << winner;
                    eng_n_d      = n_bus[{winner, 4'b0000} +: 16];
                    eng_delim1_d = delim1_bus[{winner, 3'b000} +: 8];
                    eng_delim2_d = delim2_bus[{winner, 3'b000} +: 8];
                    eng_start_d  = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (eng_result_ready) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_ONE;
                    if (wd_cnt_q == WD_LAST) begin
                        wd_err_d = 1'b1;
                        done_d   = grant_q;
                        state_d  = S_DONE;
                    end
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= 2'd3;
            grant_q      <= 4'b0000;
            done_q       <= 4'b0000;
            busy_q       <= 1'b0;
            wd_err_q     <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_n_q      <= 16'd0;
            eng_delim1_q <= 8'd0;
            eng_delim2_q <= 8'd0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            wd_err_q     <= wd_err_d;
            eng_start_q  <= eng_start_d;
            eng_n_q      <= eng_n_d;
            eng_delim1_q <= eng_delim1_d;
            eng_delim2_q <= eng_delim2_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign wd_err     = wd_err_q;
    assign eng_start  = eng_start_q;
    assign eng_n      = eng_n_q;
    assign eng_delim1 = eng_delim1_q;
    assign eng_delim2 = eng_delim2_q;

endmodule

// File: tb/tb_outdec_arbiter_4.sv
// Bench for outdec_arbiter_4: transaction-level arbiter model, a simple engine model
// and directed scenarios with literal expectations.
module tb_outdec_arbiter_4;

    localparam int WD_W = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [63:0] n_bus = 64'd0;
    logic [31:0] delim1_bus = 32'd0;
    logic [31:0] delim2_bus = 32'd0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        wd_err;
    logic        eng_start;
    logic [15:0] eng_n;
    logic [7:0]  eng_delim1;
    logic [7:0]  eng_delim2;
    logic        eng_result_ready = 1'b1;

    int total = 0;
    int bad = 0;

    outdec_arbiter_4 #(.WD_W(WD_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .n_bus(n_bus),
        .delim1_bus(delim1_bus), .delim2_bus(delim2_bus),
        .grant(grant), .done(done), .busy(busy), .wd_err(wd_err),
        .eng_start(eng_start), .eng_n(eng_n), .eng_delim1(eng_delim1),
        .eng_delim2(eng_delim2), .eng_result_ready(eng_result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine model: ready drops after sampling start, returns after eng_lat cycles.
    int    eng_lat = 5;
    int    eng_cnt = 0;
    string eng_pending = "";
    string eng_last = "";
    always @(posedge clk) begin
        if (eng_start) begin
            eng_result_ready <= 1'b0;
            eng_cnt          <= eng_lat;
            eng_pending      <= $sformatf("%0d%c%c", eng_n, eng_delim1, eng_delim2);
        end else if (!eng_result_ready) begin
            if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end else begin
                eng_result_ready <= 1'b1;
                eng_last         <= eng_pending;
            end
        end
    end

    // Arbiter model: who owns the engine, how long it has been waiting.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int s = 1; s <= 4; s++) begin
            if (r[(p + s) % 4]) return (p + s) % 4;
        end
        return -1;
    endfunction

    int          m_own = -1;
    int          m_ptr = 3;
    int          m_age = 0;
    int          m_wait = 0;
    bit          m_fin = 1'b0;
    bit          m_wd = 1'b0;
    logic [15:0] m_n = 16'd0;
    logic [7:0]  m_d1 = 8'd0;
    logic [7:0]  m_d2 = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own <= -1; m_ptr <= 3; m_age <= 0; m_wait <= 0;
            m_fin <= 1'b0; m_wd <= 1'b0; m_n <= 16'd0; m_d1 <= 8'd0; m_d2 <= 8'd0;
        end else if (m_own < 0) begin
            if (req != 4'b0000 && eng_result_ready) begin
                m_own  <= rr_pick(req, m_ptr);
                m_ptr  <= rr_pick(req, m_ptr);
                m_n    <= 16'(n_bus >> (16 * rr_pick(req, m_ptr)));
                m_d1   <= 8'(delim1_bus >> (8 * rr_pick(req, m_ptr)));
                m_d2   <= 8'(delim2_bus >> (8 * rr_pick(req, m_ptr)));
                m_age  <= 0;
                m_wait <= 0;
            end
        end else if (m_fin) begin
            m_own <= -1;
            m_fin <= 1'b0;
        end else if (m_age == 0) begin
            m_age <= 1;
        end else begin
            m_wait <= m_wait + 1;
            if (eng_result_ready) begin
                m_fin <= 1'b1;
            end else if (m_wait + 1 == (1 << WD_W) - 1) begin
                m_fin <= 1'b1;
                m_wd  <= 1'b1;
            end
        end
    end

    logic [3:0] exp_grant;
    assign exp_grant = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;

    always @(negedge clk) begin
        chk("grant", grant, exp_grant);
        chk("done", done, m_fin ? exp_grant : 4'd0);
        chk("busy", busy, m_own >= 0);
        chk("eng_start", eng_start, (m_own >= 0) && (m_age == 0) && !m_fin);
        chk("wd_err", wd_err, m_wd);
        chk("eng_n", eng_n, m_n);
        chk("eng_delim1", eng_delim1, m_d1);
        chk("eng_delim2", eng_delim2, m_d2);
    end

    logic [3:0] glog[$];
    always @(negedge clk) begin
        if (eng_start) glog.push_back(grant);
    end

    bit auto_rr = 1'b0;
    bit rearm[4] = '{default: 1'b0};

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rearm[i]) begin
                req[i]   = 1'b1;
                rearm[i] = 1'b0;
            end else if (done[i]) begin
                req[i]   = 1'b0;
                rearm[i] = auto_rr;
            end
        end
    endtask

    task automatic wait_start(input int lim);
        for (int c = 0; c < lim && !eng_start; c++) tick();
    endtask

    task automatic wait_done(input int lim);
        for (int c = 0; c < lim && done == 4'b0000; c++) tick();
    endtask

    initial begin
        int    cnt;
        bit    seen;
        string exp_s;

        #1 rst_n = 1'b0;
        n_bus      = {16'd4003, 16'd4002, 16'd4001, 16'd4000};
        delim1_bus = 32'h2C2B2A29;
        delim2_bus = 32'h3C3B3A39;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_n", eng_n, 16'd0);
        rst_n = 1'b1;
        tick();

        // Rotation: all four requesting, first winner must be 0.
        glog.delete();
        auto_rr = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 400 && glog.size() < 8; c++) tick();
        auto_rr = 1'b0;
        req = 4'b0000;
        rearm = '{default: 1'b0};
        wait_done(100);
        tick();
        tick();
        chk("rr_count", glog.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            chk($sformatf("rr_seq%0d", i), glog[i], 4'b0001 << (i % 4));
        end
        rearm = '{default: 1'b0};
        req = 4'b0000;

        // Single request with literal operands.
        n_bus[15:0] = 16'd1234;
        delim1_bus[7:0] = 8'h0D;
        delim2_bus[7:0] = 8'h0A;
        req = 4'b0001;
        tick();
        chk("t1_start", eng_start, 1'b1);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_n", eng_n, 16'd1234);
        chk("t1_d1", eng_delim1, 8'h0D);
        chk("t1_d2", eng_delim2, 8'h0A);
        wait_done(100);
        chk("t1_done", done, 4'b0001);
        tick();
        chk("t1_busy_fall", busy, 1'b0);
        exp_s = "1234\r\n";
        total++;
        if (eng_last != exp_s) begin
            bad++;
            $display("FAIL t1_text: got \"%s\" expected \"%s\"", eng_last, exp_s);
        end

        // Late req[2] with new bus data while 0 is in WAIT.
        req = 4'b0001;
        tick();
        chk("t3_start0", eng_start, 1'b1);
        tick();
        tick();
        n_bus[15:0]  = 16'd9999;
        n_bus[47:32] = 16'd2222;
        req[2] = 1'b1;
        tick();
        chk("t3_latched", eng_n, 16'd1234);
        chk("t3_grant0", grant, 4'b0001);
        wait_done(100);
        chk("t3_done0", done, 4'b0001);
        tick();
        chk("t3_idle_gap", grant, 4'd0);
        tick();
        chk("t3_grant2", grant, 4'b0100);
        chk("t3_n2", eng_n, 16'd2222);
        wait_done(100);
        chk("t3_done2", done, 4'b0100);
        tick();

        // Watchdog: engine stuck for 64 cycles.
        eng_lat = 64;
        req = 4'b0001;
        wait_start(20);
        cnt = 0;
        for (int c = 0; c < 200 && done == 4'b0000; c++) begin
            tick();
            cnt++;
        end
        chk("wd_cycles", cnt, 64);
        chk("wd_err_set", wd_err, 1'b1);
        chk("wd_done", done, 4'b0001);
        eng_lat = 5;
        tick();
        req = 4'b0010;
        wait_start(20);
        chk("wd_next_grant", grant, 4'b0010);
        wait_done(100);
        chk("wd_next_done", done, 4'b0010);
        chk("wd_sticky", wd_err, 1'b1);
        tick();

        // Reset mid-WAIT with the engine still running.
        eng_lat = 30;
        req = 4'b0001;
        wait_start(20);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", grant, 4'd0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_wd", wd_err, 1'b0);
        chk("rst_mid_n", eng_n, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        eng_lat = 5;
        seen = 1'b0;
        for (int c = 0; c < 100 && !eng_result_ready; c++) begin
            if (eng_start || done != 4'b0000 || grant != 4'b0000) seen = 1'b1;
            tick();
        end
        chk("rst_no_start", seen, 1'b0);
        chk("rst_ready_back", eng_result_ready, 1'b1);
        chk("rst_grant_held", grant, 4'd0);
        tick();
        chk("rst_start_lat", eng_start, 1'b1);
        chk("rst_start_grant", grant, 4'b0001);
        wait_done(100);
        chk("rst_done", done, 4'b0001);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
